gb_cpu_microseq: RTL and testbench

//  Parametrised M-cycle micro-op sequencer; successor to the fixed 8-step CPU scheduler.

---
 rtl/gb_cpu_microseq_if.sv | 39 +++
 rtl/gb_cpu_microseq.sv | 143 ++++++++++++++
 tb/tb_gb_cpu_microseq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/gb_cpu_microseq_if.sv
// gb_cpu_microseq_if
//   Bundles the decode-side schedule inputs and the datapath-side control outputs
//   of the M-cycle micro-op sequencer.
//   Decode-side signals: sched_steps, sched_len, sched_cb_prefix, cond_not_met,
//                        halt_req, wake, stall
//   Datapath-side signals: ctrl_o, step_o, last_o, cb_prefix_o, halted_o, len_err_o
//   master: the side that drives the schedule and observes the control word (decode/bench).
//   slave:  the sequencer itself.
interface gb_cpu_microseq_if #(
  parameter int CTRL_W    = 48,
  parameter int MAX_STEPS = 8
);
  localparam int STEP_W = $clog2(MAX_STEPS);

  logic [MAX_STEPS*CTRL_W-1:0] sched_steps;
  logic [STEP_W:0]             sched_len;
  logic                        sched_cb_prefix;
  logic                        cond_not_met;
  logic                        halt_req;
  logic                        wake;
  logic                        stall;

  logic [CTRL_W-1:0]           ctrl_o;
  logic [STEP_W-1:0]           step_o;
  logic                        last_o;
  logic                        cb_prefix_o;
  logic                        halted_o;
  logic                        len_err_o;

  modport master (
    output sched_steps, sched_len, sched_cb_prefix, cond_not_met, halt_req, wake, stall,
    input  ctrl_o, step_o, last_o, cb_prefix_o, halted_o, len_err_o
  );

  modport slave (
    input  sched_steps, sched_len, sched_cb_prefix, cond_not_met, halt_req, wake, stall,
    output ctrl_o, step_o, last_o, cb_prefix_o, halted_o, len_err_o
  );
endinterface

// File: rtl/gb_cpu_microseq.sv
// gb_cpu_microseq
//   Parametrised M-cycle micro-op sequencer. Walks the per-opcode step table supplied
//   by decode and issues one registered control word per M-cycle to the datapath.
//   Supports HALT with wake, conditional abort, step-count overflow flagging and an
//   optional datapath stall.
//   Ports: clk, reset_n (synchronous, active-low), bus (gb_cpu_microseq_if.slave).
//   Build option: define GB_CPU_MICROSEQ_STALL_EN to make bus.stall freeze all state;
//   without it bus.stall is ignored.
//
//   state | meaning
//   RUN   | issuing steps; boundary when remaining == 0 (next cycle loads step 0)
//   HALT  | issuing NOP_CTRL until wake
module gb_cpu_microseq #(
  parameter int                CTRL_W     = 48,
  parameter int                MAX_STEPS  = 8,
  parameter logic [CTRL_W-1:0] FETCH_CTRL = '0,
  parameter logic [CTRL_W-1:0] NOP_CTRL   = '0
) (
  input logic              clk,
  input logic              reset_n,
  gb_cpu_microseq_if.slave bus
);
  localparam int STEP_W = $clog2(MAX_STEPS);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   remaining_q, remaining_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                last_q, last_d;
  logic                cb_q, cb_d;
  logic                halted_q, halted_d;
  logic                len_err_q, len_err_d;

  logic [STEP_W-1:0]   step_inc;
  logic                len_over;
  logic                frozen;

  assign step_inc = step_q + 1'b1;
  assign len_over = bus.sched_len > (STEP_W+1)'(MAX_STEPS-1);

`ifdef GB_CPU_MICROSEQ_STALL_EN
  assign frozen = bus.stall;
`else
  logic stall_unused;
  assign stall_unused = bus.stall;
  assign frozen       = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    ctrl_d      = ctrl_q;
    step_d      = step_q;
    last_d      = last_q;
    cb_d        = cb_q;
    halted_d    = halted_q;
    len_err_d   = len_err_q;

    if (!frozen) begin
      case (state_q)
        RUN: begin
          if (remaining_q == '0) begin
            if (bus.halt_req) begin
              state_d  = HALT;
              ctrl_d   = NOP_CTRL;
              step_d   = '0;
              last_d   = 1'b1;
              halted_d = 1'b1;
              cb_d     = 1'b0;
            end else begin
              ctrl_d = bus.sched_steps[0 +: CTRL_W];
              step_d = '0;
              cb_d   = bus.sched_cb_prefix;
              // Overlong schedules are clamped so the index never runs past the table.
              if (len_over) begin
                remaining_d = STEP_W'(MAX_STEPS-1);
                len_err_d   = 1'b1;
              end else begin
                remaining_d = bus.sched_len[STEP_W-1:0];
              end
              last_d = (remaining_d == '0);
            end
          end else if (bus.cond_not_met) begin
            ctrl_d      = FETCH_CTRL;
            step_d      = '0;
            remaining_d = '0;
            last_d      = 1'b1;
            cb_d        = 1'b0;
          end else begin
            ctrl_d      = bus.sched_steps[step_inc*CTRL_W +: CTRL_W];
            step_d      = step_inc;
            remaining_d = remaining_q - 1'b1;
            last_d      = (remaining_q == STEP_W'(1));
          end
        end
        HALT: begin
          if (bus.wake) begin
            state_d     = RUN;
            ctrl_d      = FETCH_CTRL;
            step_d      = '0;
            remaining_d = '0;
            last_d      = 1'b1;
            halted_d    = 1'b0;
          end else begin
            ctrl_d = NOP_CTRL;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= RUN;
      remaining_q <= '0;
      ctrl_q      <= FETCH_CTRL;
      step_q      <= '0;
      last_q      <= 1'b1;
      cb_q        <= 1'b0;
      halted_q    <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      ctrl_q      <= ctrl_d;
      step_q      <= step_d;
      last_q      <= last_d;
      cb_q        <= cb_d;
      halted_q    <= halted_d;
      len_err_q   <= len_err_d;
    end
  end

  assign bus.ctrl_o      = ctrl_q;
  assign bus.step_o      = step_q;
  assign bus.last_o      = last_q;
  assign bus.cb_prefix_o = cb_q;
  assign bus.halted_o    = halted_q;
  assign bus.len_err_o   = len_err_q;
endmodule

// File: tb/tb_gb_cpu_microseq.sv
// tb_gb_cpu_microseq
//   Directed bench for gb_cpu_microseq with CTRL_W=16, MAX_STEPS=4.
//   Each cycle's outputs are compared as one packed vector:
//   {ctrl_o[15:0], step_o[1:0], last_o, cb_prefix_o, halted_o, len_err_o}.
//   Honours GB_CPU_MICROSEQ_STALL_EN to choose the stall expectation.
module tb_gb_cpu_microseq;
  localparam int CTRL_W    = 16;
  localparam int MAX_STEPS = 4;
  localparam logic [15:0] FETCH = 16'hF00D;
  localparam logic [15:0] NOP   = 16'hA0A0;
  localparam logic [15:0] W0 = 16'h1111, W1 = 16'h2222, W2 = 16'h3333, W3 = 16'h4444;
  localparam logic [15:0] C0 = 16'hC0C0, C1 = 16'hC1C1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [21:0] obs, exp;
  logic [15:0] wtab [4];

  gb_cpu_microseq_if #(.CTRL_W(CTRL_W), .MAX_STEPS(MAX_STEPS)) bus ();

  gb_cpu_microseq #(
    .CTRL_W(CTRL_W), .MAX_STEPS(MAX_STEPS), .FETCH_CTRL(FETCH), .NOP_CTRL(NOP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign obs = {bus.ctrl_o, bus.step_o, bus.last_o, bus.cb_prefix_o, bus.halted_o, bus.len_err_o};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.sched_steps = {W3, W2, W1, W0};
    bus.sched_len = 3'd0; bus.sched_cb_prefix = 1'b0; bus.cond_not_met = 1'b0;
    bus.halt_req = 1'b0; bus.wake = 1'b0; bus.stall = 1'b0;
    reset_n = 1'b0;
    tick(); tick();
    exp = {FETCH, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset got %h exp %h", obs, exp); end
    reset_n = 1'b1;
  endtask

  task automatic test_sequence();
    wtab[0] = W0; wtab[1] = W1; wtab[2] = W2; wtab[3] = W3;
    bus.sched_len = 3'd3;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp = {wtab[k], 2'(k), (k == 3), 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL seq_step%0d got %h exp %h", k, obs, exp); end
    end
    bus.sched_len = 3'd0;
    tick();
    exp = {W0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL seq_boundary got %h exp %h", obs, exp); end
  endtask

  task automatic test_cond_abort();
    bus.sched_len = 3'd3; bus.sched_cb_prefix = 1'b1;
    tick();
    exp = {W0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL abort_w0 got %h exp %h", obs, exp); end
    tick();
    exp = {W1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL abort_w1 got %h exp %h", obs, exp); end
    bus.cond_not_met = 1'b1;
    tick();
    exp = {FETCH, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL abort_fetch got %h exp %h", obs, exp); end
    // cond_not_met at a boundary must not block the step-0 load
    bus.sched_len = 3'd2; bus.sched_cb_prefix = 1'b0;
    tick();
    exp = {W0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL abort_boundary got %h exp %h", obs, exp); end
    bus.cond_not_met = 1'b0;
    tick(); tick();
    exp = {W2, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL abort_resume got %h exp %h", obs, exp); end
  endtask

  task automatic test_cb_prefix();
    bus.sched_cb_prefix = 1'b1; bus.sched_len = 3'd0;
    tick();
    exp = {W0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL cb_prefix got %h exp %h", obs, exp); end
    bus.sched_steps = {W3, W2, C1, C0};
    bus.sched_cb_prefix = 1'b0; bus.sched_len = 3'd1;
    tick();
    exp = {C0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL cb_op0 got %h exp %h", obs, exp); end
    tick();
    exp = {C1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL cb_op1 got %h exp %h", obs, exp); end
    bus.sched_steps = {W3, W2, W1, W0};
  endtask

  task automatic test_halt();
    bus.halt_req = 1'b1; bus.wake = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({bus.ctrl_o, bus.halted_o, bus.cb_prefix_o} !== {NOP, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL halt_nop%0d got %h/%b exp %h/1", k, bus.ctrl_o, bus.halted_o, NOP);
      end
    end
    bus.wake = 1'b1;
    tick();
    exp = {FETCH, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL halt_wake got %h exp %h", obs, exp); end
    // simultaneous halt_req and wake at a boundary: one HALT cycle then out
    tick();
    checks++;
    if ({bus.ctrl_o, bus.halted_o} !== {NOP, 1'b1}) begin
      errors++; $display("FAIL halt_both_in got %h/%b exp %h/1", bus.ctrl_o, bus.halted_o, NOP);
    end
    bus.halt_req = 1'b0;
    tick();
    exp = {FETCH, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL halt_both_out got %h exp %h", obs, exp); end
    bus.wake = 1'b0;
  endtask

  task automatic test_len_err();
    bus.sched_len = 3'd6; bus.sched_cb_prefix = 1'b0;
    tick();
    exp = {W0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL lenerr_w0 got %h exp %h", obs, exp); end
    tick();
    tick();
    exp = {W2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL lenerr_w2 got %h exp %h", obs, exp); end
`ifdef GB_CPU_MICROSEQ_STALL_EN
    bus.stall = 1'b1; bus.cond_not_met = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL stall_hold%0d got %h exp %h", k, obs, exp); end
    end
    bus.stall = 1'b0; bus.cond_not_met = 1'b0;
`else
    bus.stall = 1'b1;
`endif
    tick();
    bus.stall = 1'b0;
    exp = {W3, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL lenerr_w3 got %h exp %h", obs, exp); end
    bus.sched_len = 3'd0;
    tick();
    exp = {W0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL lenerr_sticky got %h exp %h", obs, exp); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_cond_abort();
    test_cb_prefix();
    test_halt();
    test_len_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
